// File: rtl/uart_move_parser.sv
// uart_move_parser
// Parses tic-tac-toe commands from the uart receive character stream.
//   "P<d><CR>" : play cell d (ASCII '1'..'9'), held as move_pos 0..8 under
//                a move_valid/move_ready handshake.
//   "R<CR>"    : one-cycle restart pulse.
// LF characters are ignored everywhere. Parity failures, malformed commands,
// inter-character gaps and characters arriving while a move is pending
// produce a one-cycle err pulse with a sticky err_code.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   rx_data      received character (valid with rx_valid)
//   rx_valid     one-cycle strobe per received character
//   rx_parity_ok parity verdict for rx_data
//   move_pos     decoded cell index 0..8, stable while move_valid
//   move_valid   decoded move pending
//   move_ready   consumer accepts the pending move
//   restart      one-cycle pulse on "R<CR>"
//   err          one-cycle error pulse
//   err_code     0 parity, 1 syntax, 2 timeout, 3 overrun; held until next err
module uart_move_parser #(
   parameter int DATA_W      = 7,
   parameter int GAP_TIMEOUT = 21700,
   parameter int TMR_W       = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] rx_data,
   input  logic              rx_valid,
   input  logic              rx_parity_ok,
   output logic [3:0]        move_pos,
   output logic              move_valid,
   input  logic              move_ready,
   output logic              restart,
   output logic              err,
   output logic [1:0]        err_code
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      GOT_P   = 3'd1,
      GOT_R   = 3'd2,
      GOT_DIG = 3'd3,
      HOLD    = 3'd4
   } state_t;

   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GAP_TIMEOUT - 1);

   localparam logic [1:0] E_PARITY  = 2'd0;
   localparam logic [1:0] E_SYNTAX  = 2'd1;
   localparam logic [1:0] E_TIMEOUT = 2'd2;
   localparam logic [1:0] E_OVERRUN = 2'd3;

   function automatic logic is_p(input logic [DATA_W-1:0] c);
      return (c == DATA_W'('h50)) || (c == DATA_W'('h70));
   endfunction

   function automatic logic is_r(input logic [DATA_W-1:0] c);
      return (c == DATA_W'('h52)) || (c == DATA_W'('h72));
   endfunction

   function automatic logic is_dig(input logic [DATA_W-1:0] c);
      return (c >= DATA_W'('h31)) && (c <= DATA_W'('h39));
   endfunction

   function automatic logic is_cr(input logic [DATA_W-1:0] c);
      return c == DATA_W'('h0D);
   endfunction

   function automatic logic is_lf(input logic [DATA_W-1:0] c);
      return c == DATA_W'('h0A);
   endfunction

   state_t             state, state_n;
   logic [3:0]         digit_q, digit_n;
   logic [3:0]         pos_n;
   logic               restart_n, err_n;
   logic [1:0]         code_n;
   logic [TMR_W-1:0]   timer, timer_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         digit_q  <= '0;
         move_pos <= '0;
         restart  <= 1'b0;
         err      <= 1'b0;
         err_code <= '0;
         timer    <= '0;
      end else begin
         state    <= state_n;
         digit_q  <= digit_n;
         move_pos <= pos_n;
         restart  <= restart_n;
         err      <= err_n;
         err_code <= code_n;
         timer    <= timer_n;
      end
   end

   assign move_valid = (state == HOLD);

   always_comb begin
      state_n   = state;
      digit_n   = digit_q;
      pos_n     = move_pos;
      restart_n = 1'b0;
      err_n     = 1'b0;
      code_n    = err_code;
      // Timer defaults to 0: this covers IDLE/HOLD, state entry and every
      // accepted character. Only an idle cycle in a GOT_* state counts up.
      timer_n   = '0;

      if (state == HOLD) begin
         // Parity is irrelevant here; any real character is an overrun.
         if (rx_valid && !is_lf(rx_data)) begin
            err_n  = 1'b1;
            code_n = E_OVERRUN;
         end
         if (move_ready)
            state_n = IDLE;
      end else if (rx_valid && !rx_parity_ok) begin
         err_n   = 1'b1;
         code_n  = E_PARITY;
         state_n = IDLE;
      end else if (rx_valid && !is_lf(rx_data)) begin
         case (state)
            IDLE: begin
               if (is_p(rx_data))
                  state_n = GOT_P;
               else if (is_r(rx_data))
                  state_n = GOT_R;
            end
            GOT_P: begin
               if (is_dig(rx_data)) begin
                  // '1'..'9' low nibble is 1..9, so nibble-1 is the cell index.
                  digit_n = rx_data[3:0] - 4'd1;
                  state_n = GOT_DIG;
               end else begin
                  err_n  = 1'b1;
                  code_n = E_SYNTAX;
                  // A stray P restarts the command rather than dropping it.
                  state_n = is_p(rx_data) ? GOT_P : IDLE;
               end
            end
            GOT_DIG: begin
               if (is_cr(rx_data)) begin
                  pos_n   = digit_q;
                  state_n = HOLD;
               end else begin
                  err_n   = 1'b1;
                  code_n  = E_SYNTAX;
                  state_n = is_p(rx_data) ? GOT_P : IDLE;
               end
            end
            GOT_R: begin
               if (is_cr(rx_data)) begin
                  restart_n = 1'b1;
                  state_n   = IDLE;
               end else begin
                  err_n   = 1'b1;
                  code_n  = E_SYNTAX;
                  state_n = is_p(rx_data) ? GOT_P : IDLE;
               end
            end
            default: state_n = IDLE;
         endcase
      end else if (state != IDLE) begin
         // Mid-command with no character this cycle (LF counts as none).
         if (timer == TMR_LAST) begin
            err_n   = 1'b1;
            code_n  = E_TIMEOUT;
            state_n = IDLE;
         end else begin
            timer_n = timer + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_move_parser.sv
module tb_uart_move_parser;

   localparam int GAP = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] rx_data;
   logic       rx_valid;
   logic       rx_parity_ok;
   logic [3:0] move_pos;
   logic       move_valid;
   logic       move_ready;
   logic       restart;
   logic       err;
   logic [1:0] err_code;

   int vectors     = 0;
   int miscompares = 0;

   uart_move_parser #(
      .DATA_W(7),
      .GAP_TIMEOUT(GAP),
      .TMR_W(5)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .rx_parity_ok(rx_parity_ok),
      .move_pos(move_pos),
      .move_valid(move_valid),
      .move_ready(move_ready),
      .restart(restart),
      .err(err),
      .err_code(err_code)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [6:0] c, input logic ok);
      rx_data      = c;
      rx_valid     = 1'b1;
      rx_parity_ok = ok;
      tick();
      rx_valid     = 1'b0;
      rx_parity_ok = 1'b1;
      rx_data      = 7'h00;
   endtask

   task automatic consume();
      move_ready = 1'b1;
      tick();
      move_ready = 1'b0;
   endtask

   initial begin
      reset        = 1'b1;
      rx_data      = 7'h00;
      rx_valid     = 1'b0;
      rx_parity_ok = 1'b1;
      move_ready   = 1'b0;
      tick();
      tick();
      chk("rst_mv",   32'(move_valid), 0);
      chk("rst_pos",  32'(move_pos),   0);
      chk("rst_rs",   32'(restart),    0);
      chk("rst_err",  32'(err),        0);
      chk("rst_code", 32'(err_code),   0);
      reset = 1'b0;
      tick();

      // 1: "P5\r" -> cell 4, held until accepted
      send(7'h50, 1'b1);
      send(7'h35, 1'b1);
      chk("t1_mv_early", 32'(move_valid), 0);
      send(7'h0D, 1'b1);
      for (int i = 0; i < 20; i++) begin
         chk("t1_mv_hold",  32'(move_valid), 1);
         chk("t1_pos_hold", 32'(move_pos),   4);
         tick();
      end
      consume();
      chk("t1_mv_done", 32'(move_valid), 0);
      chk("t1_err",     32'(err),        0);

      // 2: "r\r" -> one-cycle restart
      send(7'h72, 1'b1);
      chk("t2_rs_early", 32'(restart), 0);
      send(7'h0D, 1'b1);
      chk("t2_rs",  32'(restart),    1);
      chk("t2_err", 32'(err),        0);
      chk("t2_mv",  32'(move_valid), 0);
      tick();
      chk("t2_rs_end", 32'(restart), 0);

      // 3: parity failure on the digit, then "P2\r"
      send(7'h50, 1'b1);
      send(7'h36, 1'b0);
      chk("t3_err",  32'(err),      1);
      chk("t3_code", 32'(err_code), 0);
      tick();
      chk("t3_err_end", 32'(err), 0);
      send(7'h0D, 1'b1);
      chk("t3_idle_mv", 32'(move_valid), 0);
      send(7'h50, 1'b1);
      send(7'h32, 1'b1);
      send(7'h0D, 1'b1);
      chk("t3_mv",  32'(move_valid), 1);
      chk("t3_pos", 32'(move_pos),   1);
      consume();

      // 4: gap timeout exactly GAP cycles after the P strobe
      send(7'h50, 1'b1);
      for (int k = 1; k < GAP; k++) begin
         chk("t4_no_err", 32'(err), 0);
         tick();
      end
      chk("t4_no_err_last", 32'(err), 0);
      tick();
      chk("t4_err",  32'(err),      1);
      chk("t4_code", 32'(err_code), 2);
      tick();
      chk("t4_err_end", 32'(err), 0);
      // digit arrives on the would-be expiry edge: it wins
      send(7'h50, 1'b1);
      for (int k = 1; k < GAP; k++) tick();
      send(7'h33, 1'b1);
      chk("t4b_no_err", 32'(err), 0);
      send(7'h0D, 1'b1);
      chk("t4b_err", 32'(err),        0);
      chk("t4b_mv",  32'(move_valid), 1);
      chk("t4b_pos", 32'(move_pos),   2);
      consume();

      // 5: overrun in HOLD on the accept cycle
      send(7'h50, 1'b1);
      send(7'h39, 1'b1);
      send(7'h0D, 1'b1);
      chk("t5_mv",  32'(move_valid), 1);
      chk("t5_pos", 32'(move_pos),   8);
      rx_data    = 7'h31;
      rx_valid   = 1'b1;
      move_ready = 1'b1;
      tick();
      rx_valid   = 1'b0;
      move_ready = 1'b0;
      chk("t5_err",     32'(err),        1);
      chk("t5_code",    32'(err_code),   3);
      chk("t5_mv_done", 32'(move_valid), 0);
      tick();
      chk("t5_err_end", 32'(err), 0);
      send(7'h0D, 1'b1);
      chk("t5_idle_err", 32'(err),        0);
      chk("t5_idle_mv",  32'(move_valid), 0);

      // 6: syntax errors and resync
      send(7'h50, 1'b1);
      send(7'h58, 1'b1);
      chk("t6_err",  32'(err),      1);
      chk("t6_code", 32'(err_code), 1);
      tick();
      send(7'h0D, 1'b1);
      chk("t6_idle_mv", 32'(move_valid), 0);
      chk("t6_idle_rs", 32'(restart),    0);
      send(7'h50, 1'b1);
      send(7'h50, 1'b1);
      chk("t6_pp_err",  32'(err),      1);
      chk("t6_pp_code", 32'(err_code), 1);
      send(7'h33, 1'b1);
      chk("t6_dig_err", 32'(err), 0);
      send(7'h0D, 1'b1);
      chk("t6_mv",  32'(move_valid), 1);
      chk("t6_pos", 32'(move_pos),   2);
      consume();
      // reset in the middle of "P7"
      send(7'h50, 1'b1);
      send(7'h37, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_rst_mv",   32'(move_valid), 0);
      chk("t6_rst_pos",  32'(move_pos),   0);
      chk("t6_rst_err",  32'(err),        0);
      chk("t6_rst_code", 32'(err_code),   0);
      chk("t6_rst_rs",   32'(restart),    0);
      tick();
      reset = 1'b0;
      tick();
      send(7'h0D, 1'b1);
      chk("t6_after_mv",  32'(move_valid), 0);
      chk("t6_after_err", 32'(err),        0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_move_parser.md
Name: uart_move_parser

Overview:
Downstream consumer of the uart receive path. Takes each received 7-bit ASCII character plus its parity verdict and parses tic-tac-toe commands: "P<d><CR>" plays a move on cell d (1..9), and "R<CR>" restarts the game. A decoded move is held for the game FSM under a valid/ready handshake. Malformed input, parity failures, inter-character timeouts and overruns are reported with an error strobe and code.

Parameters:
DATA_W, 7, character width; matches the uart parallel data width.
GAP_TIMEOUT, 21700, max idle cycles between characters inside a command. Default is 10 character times at 217 clocks/bit.
TMR_W, 15, width of the gap timer; must satisfy 2^TMR_W > GAP_TIMEOUT.

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
rx_data  in  DATA_W  received character, valid only while rx_valid=1
rx_valid  in  1  one-cycle strobe, one character per strobe
rx_parity_ok  in  1  parity verdict for rx_data, sampled with rx_valid
move_pos  out  4  cell index 0..8 (ASCII digit minus 0x31); held while move_valid=1
move_valid  out  1  decoded move available
move_ready  in  1  game FSM accepts the move
restart  out  1  one-cycle pulse on a valid "R<CR>"
err  out  1  one-cycle error pulse
err_code  out  2  error cause: 0 parity, 1 syntax, 2 timeout, 3 overrun; holds until the next err

Behaviour:
- Reset (async, while reset=1): state IDLE, move_pos=0, move_valid=0, restart=0, err=0, err_code=0, gap timer=0. Reset mid-command or mid-HOLD discards everything; no err is raised.
- Character classes:
  - P: 0x50 or 0x70.
  - R: 0x52 or 0x72.
  - DIG: 0x31..0x39.
  - CR: 0x0D.
  - LF: 0x0A, always ignored, never an error.
- Parity: rx_valid=1 with rx_parity_ok=0 in any state except HOLD gives err with code 0 and next state IDLE. The character is discarded.
- States and transitions on an accepted rx_valid:
  - IDLE: P goes to GOT_P. R goes to GOT_R. Anything else is ignored silently.
  - GOT_P: DIG latches the digit and goes to GOT_DIG. P stays in GOT_P with err code 1 (resync). Other goes to IDLE with err code 1.
  - GOT_DIG: CR goes to HOLD and loads move_pos = digit-0x31. P goes to GOT_P with err code 1. Other goes to IDLE with err code 1.
  - GOT_R: CR pulses restart and goes to IDLE. P goes to GOT_P with err code 1. Other goes to IDLE with err code 1.
  - HOLD: move_valid=1 and move_pos is stable. move_ready=1 takes the state to IDLE on the next cycle with move_valid=0. Any rx_valid in HOLD is dropped with err code 3, including the cycle where move_ready=1.
- Latency: the terminating character accepted in cycle N gives move_valid, restart or err asserted in cycle N+1. restart and err last exactly 1 cycle.
- Gap timer:
  - Cleared on entering GOT_P, GOT_R or GOT_DIG and on every accepted rx_valid.
  - Increments each cycle while in those states.
  - When it reaches GAP_TIMEOUT-1 with no rx_valid that cycle, the block raises err with code 2 and returns to IDLE.
  - rx_valid on the expiry cycle wins and no timeout is raised.
  - The timer is held at 0 in IDLE and HOLD.
- err and restart are never asserted in the same cycle. move_valid deasserts only after a cycle with move_ready=1.

Test Plan:
1. Reset, then send 0x50, 0x35, 0x0D with parity ok, move_ready=0. Expect move_valid=1 and move_pos=4 from the cycle after CR, stable for 20 cycles. Then pulse move_ready for 1 cycle: move_valid=0 on the next cycle.
2. Send 0x72, 0x0D. Expect restart high for exactly 1 cycle, err=0, move_valid=0.
3. Send 0x50, then 0x36 with rx_parity_ok=0. Expect err pulse with err_code=0 and state IDLE. A following "P2\r" yields move_pos=1.
4. Send 0x50, then no characters. Expect err with err_code=2 exactly GAP_TIMEOUT cycles after the P strobe. A repeat that sends a digit on the cycle before expiry gives no err.
5. Reach HOLD with "P9\r" (move_pos=8). Send 0x31 while move_ready=1 in the same cycle. Expect err_code=3, the move consumed, and the 0x31 not starting a command.
6. Send "PX", i.e. 0x50, 0x58. Expect err_code=1, state IDLE. Then "PP3\r" gives err_code=1 on the second P, followed by move_pos=2. Assert reset mid-"P7" and expect all outputs 0 and no move.
